// File: rtl/mdu_pkg.sv
// Shared encodings and helpers for the iterative multiply/divide unit.
package mdu_pkg;

   localparam int MDU_WIDTH = 32;

   typedef enum logic [1:0] {
      OP_MULT  = 2'b00,
      OP_MULTU = 2'b01,
      OP_DIV   = 2'b10,
      OP_DIVU  = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_RUN  = 2'b01,
      S_SIGN = 2'b10
   } state_e;

   function automatic logic op_is_signed(input logic [1:0] op);
      return ~op[0];
   endfunction

   function automatic logic op_is_div(input logic [1:0] op);
      return op[1];
   endfunction

endpackage

// File: rtl/mdu_cond_neg.sv
// Combinational negate-if-flag: returns the value or its two's complement.
module mdu_cond_neg #(
   parameter int W = 32
) (
   input  logic [W-1:0] i_val,
   input  logic         i_neg,
   output logic [W-1:0] o_val
);

   assign o_val = i_neg ? ((~i_val) + W'(1)) : i_val;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative shift-add multiplier / restoring divider with HI/LO registers.
// Magnitudes are processed in RUN; signs are applied when HI/LO are written in SIGN.
//
//   state  | meaning
//   S_IDLE | waiting for start; MTHI/MTLO writes accepted
//   S_RUN  | one multiply or divide step per cycle, WIDTH cycles
//   S_SIGN | sign fix-up, HI/LO written, done raised for next cycle
module mult_div_unit
   import mdu_pkg::*;
#(
   parameter int WIDTH = MDU_WIDTH
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             flush,
   input  logic             we_hi,
   input  logic             we_lo,
   input  logic [WIDTH-1:0] wd,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = $clog2(WIDTH);

   state_e             r_state;
   logic [CW-1:0]      r_cnt;
   logic [2*WIDTH-1:0] r_acc;
   logic [WIDTH-1:0]   r_opb;
   logic               r_is_div;
   logic               r_neg_res;
   logic               r_neg_rem;
   logic               r_div_zero;
   logic [WIDTH-1:0]   r_hi;
   logic [WIDTH-1:0]   r_lo;
   logic               r_busy;
   logic               r_done;

   logic               w_signed;
   logic               w_a_neg;
   logic               w_b_neg;
   logic [WIDTH-1:0]   w_a_mag;
   logic [WIDTH-1:0]   w_b_mag;
   logic [WIDTH:0]     w_mul_sum;
   logic [2*WIDTH-1:0] w_mul_next;
   logic [WIDTH:0]     w_div_shift;
   logic [WIDTH:0]     w_div_diff;
   logic [2*WIDTH-1:0] w_div_next;
   logic [2*WIDTH-1:0] w_prod;
   logic [WIDTH-1:0]   w_quo;
   logic [WIDTH-1:0]   w_rem;

   assign w_signed = op_is_signed(op);
   assign w_a_neg  = w_signed & a[WIDTH-1];
   assign w_b_neg  = w_signed & b[WIDTH-1];

   mdu_cond_neg #(.W(WIDTH)) u_abs_a (.i_val(a), .i_neg(w_a_neg), .o_val(w_a_mag));
   mdu_cond_neg #(.W(WIDTH)) u_abs_b (.i_val(b), .i_neg(w_b_neg), .o_val(w_b_mag));

   // Multiply: upper half accumulates the multiplicand, lower half shifts out multiplier bits.
   assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, (r_acc[0] ? r_opb : '0)};
   assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

   // Divide: upper half is the partial remainder, lower half collects quotient bits.
   assign w_div_shift = r_acc[2*WIDTH-1:WIDTH-1];
   assign w_div_diff  = w_div_shift - {1'b0, r_opb};
   assign w_div_next  = w_div_diff[WIDTH]
                      ? {w_div_shift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                      : {w_div_diff[WIDTH-1:0],  r_acc[WIDTH-2:0], 1'b1};

   mdu_cond_neg #(.W(2*WIDTH)) u_fix_prod (.i_val(r_acc), .i_neg(r_neg_res), .o_val(w_prod));
   mdu_cond_neg #(.W(WIDTH))   u_fix_quo  (.i_val(r_acc[WIDTH-1:0]), .i_neg(r_neg_res), .o_val(w_quo));
   mdu_cond_neg #(.W(WIDTH))   u_fix_rem  (.i_val(r_acc[2*WIDTH-1:WIDTH]), .i_neg(r_neg_rem), .o_val(w_rem));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_acc      <= '0;
         r_opb      <= '0;
         r_is_div   <= 1'b0;
         r_neg_res  <= 1'b0;
         r_neg_rem  <= 1'b0;
         r_div_zero <= 1'b0;
         r_hi       <= '0;
         r_lo       <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  if (!flush) begin
                     r_is_div   <= op_is_div(op);
                     r_neg_res  <= w_a_neg ^ w_b_neg;
                     r_neg_rem  <= w_a_neg;
                     r_div_zero <= (b == '0);
                     r_opb      <= op_is_div(op) ? w_b_mag : w_a_mag;
                     r_acc      <= {{WIDTH{1'b0}}, (op_is_div(op) ? w_a_mag : w_b_mag)};
                     r_cnt      <= CW'(WIDTH - 1);
                     r_busy     <= 1'b1;
                     r_state    <= S_RUN;
                  end
               end else begin
                  if (we_hi) r_hi <= wd;
                  if (we_lo) r_lo <= wd;
               end
            end
            S_RUN: begin
               if (flush) begin
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end else begin
                  r_acc <= r_is_div ? w_div_next : w_mul_next;
                  if (r_cnt == '0) r_state <= S_SIGN;
                  else             r_cnt   <= r_cnt - CW'(1);
               end
            end
            S_SIGN: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
               if (!flush) begin
                  r_done <= 1'b1;
                  if (r_is_div) begin
                     // A zero divisor leaves |a| as remainder, so the sign fix restores raw a.
                     r_hi <= w_rem;
                     r_lo <= r_div_zero ? '1 : w_quo;
                  end else begin
                     r_hi <= w_prod[2*WIDTH-1:WIDTH];
                     r_lo <= w_prod[WIDTH-1:0];
                  end
               end
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign busy = r_busy;
   assign done = r_done;
   assign hi   = r_hi;
   assign lo   = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: directed corner cases plus random ops against an arithmetic model.
module tb_mult_div_unit;

   localparam int W = 32;
   localparam logic [1:0] T_MULT  = 2'b00;
   localparam logic [1:0] T_MULTU = 2'b01;
   localparam logic [1:0] T_DIV   = 2'b10;
   localparam logic [1:0] T_DIVU  = 2'b11;

   logic          clk;
   logic          reset_n;
   logic          start;
   logic [1:0]    op;
   logic [W-1:0]  a;
   logic [W-1:0]  b;
   logic          flush;
   logic          we_hi;
   logic          we_lo;
   logic [W-1:0]  wd;
   logic          busy;
   logic          done;
   logic [W-1:0]  hi;
   logic [W-1:0]  lo;

   int checks = 0;
   int errors = 0;
   logic [W-1:0] m_hi = '0;
   logic [W-1:0] m_lo = '0;

   mult_div_unit dut (
      .clk(clk), .reset_n(reset_n), .start(start), .op(op), .a(a), .b(b),
      .flush(flush), .we_hi(we_hi), .we_lo(we_lo), .wd(wd),
      .busy(busy), .done(done), .hi(hi), .lo(lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL timeout obs=running exp=finished");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] ref_result(input logic [1:0] o, input logic [W-1:0] x,
                                              input logic [W-1:0] y);
      longint p;
      int     q;
      int     r;
      case (o)
         T_MULT: begin
            p = longint'($signed(x)) * longint'($signed(y));
            return p;
         end
         T_MULTU: return {32'h0, x} * {32'h0, y};
         default: begin
            if (y == 0) return {x, 32'hFFFF_FFFF};
            if (o == T_DIVU) return {x % y, x / y};
            if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
            q = $signed(x) / $signed(y);
            r = $signed(x) % $signed(y);
            return {r, q};
         end
      endcase
   endfunction

   // Called at a negedge; returns #1 after the launch edge.
   task automatic launch(input logic [1:0] o, input logic [W-1:0] va, input logic [W-1:0] vb);
      start = 1'b1; op = o; a = va; b = vb;
      @(posedge clk);
      #1;
      start = 1'b0; we_hi = 1'b0; we_lo = 1'b0;
      a = $urandom; b = $urandom; op = 2'($urandom);
   endtask

   task automatic wait_check(input logic [1:0] o, input logic [W-1:0] va, input logic [W-1:0] vb,
                             input bit poke);
      logic [63:0] r;
      r = ref_result(o, va, vb);
      for (int k = 0; k <= W; k++) begin
         @(negedge clk);
         start = 1'b0; we_lo = 1'b0;
         a = $urandom; b = $urandom;
         chk("busy_run", {busy, done}, 2'b10);
         chk("hold_run", {hi, lo}, {m_hi, m_lo});
         if (poke && k == 15) begin
            start = 1'b1; op = T_DIVU; we_lo = 1'b1; wd = $urandom;
         end
      end
      @(negedge clk);
      start = 1'b0; we_lo = 1'b0;
      chk("done_pulse", {busy, done}, 2'b01);
      chk("result", {hi, lo}, r);
      m_hi = r[63:32];
      m_lo = r[31:0];
   endtask

   task automatic run_op(input logic [1:0] o, input logic [W-1:0] va, input logic [W-1:0] vb,
                         input bit poke);
      launch(o, va, vb);
      wait_check(o, va, vb, poke);
   endtask

   task automatic mv(input bit h, input bit l, input logic [W-1:0] d);
      we_hi = h; we_lo = l; wd = d;
      @(posedge clk);
      #1;
      we_hi = 1'b0; we_lo = 1'b0;
      if (h) m_hi = d;
      if (l) m_lo = d;
      @(negedge clk);
      chk("move", {hi, lo}, {m_hi, m_lo});
      chk("move_idle", {busy, done}, 2'b00);
   endtask

   initial begin
      logic [1:0]   ro;
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      reset_n = 1'b1;
      start = 1'b0; op = '0; a = '0; b = '0; flush = 1'b0;
      we_hi = 1'b0; we_lo = 1'b0; wd = '0;
      #1 reset_n = 1'b0;
      #2;
      chk("rst_hi", hi, 0);
      chk("rst_lo", lo, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      @(negedge clk);
      reset_n = 1'b1;

      mv(1'b1, 1'b0, 32'h0000_1234);
      mv(1'b0, 1'b1, 32'hCAFE_0001);
      mv(1'b1, 1'b1, 32'h0BAD_F00D);

      run_op(T_MULT,  32'h0000_0007, 32'hFFFF_FFFD, 1'b1);
      run_op(T_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      run_op(T_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 1'b0);
      run_op(T_DIVU,  32'd100,       32'h0,         1'b0);
      run_op(T_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      run_op(T_DIV,   32'hFFFF_FFF9, 32'h0,         1'b0);

      // start and a move in the same idle cycle: the move must be dropped
      we_hi = 1'b1; wd = 32'hDEAD_BEEF;
      run_op(T_MULTU, 32'h0001_0003, 32'h0002_0005, 1'b0);

      launch(T_DIV, 32'h1234_5678, 32'h0000_0013);
      repeat (10) @(negedge clk);
      flush = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0;
      @(negedge clk);
      chk("flush_busy", {busy, done}, 2'b00);
      repeat (40) begin
         @(negedge clk);
         chk("flush_nodone", done, 0);
         chk("flush_hold", {hi, lo}, {m_hi, m_lo});
      end

      start = 1'b1; flush = 1'b1; op = T_MULT; a = 32'h5; b = 32'h9;
      @(posedge clk);
      #1 start = 1'b0; flush = 1'b0;
      repeat (36) begin
         @(negedge clk);
         chk("flush_start", {busy, done}, 2'b00);
         chk("flush_start_hold", {hi, lo}, {m_hi, m_lo});
      end

      launch(T_MULT, 32'h0000_4321, 32'h8765_0000);
      repeat (12) @(negedge clk);
      reset_n = 1'b0;
      #1;
      chk("arst_hi", hi, 0);
      chk("arst_lo", lo, 0);
      chk("arst_busy", busy, 0);
      chk("arst_done", done, 0);
      m_hi = '0; m_lo = '0;
      @(negedge clk);
      reset_n = 1'b1;
      repeat (36) begin
         @(negedge clk);
         chk("arst_idle", {busy, done, hi, lo}, 66'h0);
      end

      for (int i = 0; i < 48; i++) begin
         ro = 2'($urandom);
         ra = $urandom;
         rb = $urandom;
         case ($urandom_range(0, 7))
            0: rb = '0;
            1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            2: rb = 32'($urandom_range(1, 20));
            3: ra = 32'($urandom_range(0, 50));
            default: ;
         endcase
         if ($urandom_range(0, 4) == 0) mv(1'($urandom), 1'($urandom), $urandom);
         run_op(ro, ra, rb, ($urandom_range(0, 3) == 0));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
